// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU data, instruction fetch and optional host/loader ports.
// Define MEM_ARB_HOST_PORT_EN to enable the lowest-priority host port.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [3:0]        starve_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OWN_D, OWN_I, OWN_H} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        starve_q, starve_d;

  logic   hostReq;
  logic   dElig, iElig, hElig;
  logic   grantValid;
  owner_t grantId;

`ifdef MEM_ARB_HOST_PORT_EN
  assign hostReq = h_req;
`else
  logic unusedHost;
  assign hostReq    = 1'b0;
  assign unusedHost = ^{h_req, h_we, h_addr, h_wdata};
`endif

  // In DONE the finishing owner's request is masked so its still-high req is not re-granted.
  always_comb begin
    dElig      = d_req   && !(state_q == DONE && owner_q == OWN_D);
    iElig      = i_req   && !(state_q == DONE && owner_q == OWN_I);
    hElig      = hostReq && !(state_q == DONE && owner_q == OWN_H);
    grantValid = 1'b0;
    grantId    = OWN_D;
    if (state_q != BUSY) begin
      if (iElig && starve_q == STARVE_LIM) begin
        grantValid = 1'b1;
        grantId    = OWN_I;
      end else if (dElig) begin
        grantValid = 1'b1;
        grantId    = OWN_D;
      end else if (iElig) begin
        grantValid = 1'b1;
        grantId    = OWN_I;
      end else if (hElig) begin
        grantValid = 1'b1;
        grantId    = OWN_H;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    starve_d    = starve_q;
    case (state_q)
      IDLE, DONE: begin
        if (grantValid) begin
          state_d   = BUSY;
          owner_d   = grantId;
          ram_req_d = 1'b1;
          case (grantId)
            OWN_D: begin
              ram_we_d    = d_we;
              ram_addr_d  = d_addr;
              ram_wdata_d = d_wdata;
            end
            OWN_I: begin
              ram_we_d   = 1'b0;
              ram_addr_d = i_addr;
            end
`ifdef MEM_ARB_HOST_PORT_EN
            OWN_H: begin
              ram_we_d    = h_we;
              ram_addr_d  = h_addr;
              ram_wdata_d = h_wdata;
            end
`endif
            default: ;
          endcase
          if (grantId == OWN_I) begin
            starve_d = 4'd0;
          end else if (grantId == OWN_D && i_req && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          state_d   = DONE;
          ram_req_d = 1'b0;
          if (!ram_we_q) begin
            rdata_d = ram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign d_valid = (state_q == DONE) && (owner_q == OWN_D);
  assign i_valid = (state_q == DONE) && (owner_q == OWN_I);
`ifdef MEM_ARB_HOST_PORT_EN
  assign h_valid = (state_q == DONE) && (owner_q == OWN_H);
`else
  assign h_valid = 1'b0;
`endif

  assign ram_req    = ram_req_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rdata      = rdata_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small wait-state-programmable memory model.
// Host-port expectations follow MEM_ARB_HOST_PORT_EN when it is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        d_req, d_we, i_req, h_req, h_we;
  logic [31:0] d_addr, d_wdata, i_addr, h_addr, h_wdata;
  logic        d_valid, i_valid, h_valid;
  logic [31:0] rdata;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  starve_cnt;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mem [0:255];
  bit          memLoaded;
  int          waitStates;
  int          busyCnt;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_valid(h_valid),
    .rdata(rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks in the (waitStates+1)th cycle of ram_req; word k preloads to 0x10000000+k.
  assign ram_ack   = ram_req && (busyCnt == waitStates);
  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      mem[8'h40] <= 32'hDEAD_BEEF;
      memLoaded  <= 1'b1;
    end else if (ram_ack && ram_we) begin
      mem[ram_addr[9:2]] <= ram_wdata;
    end
    if (ram_req && !ram_ack) busyCnt <= busyCnt + 1;
    else busyCnt <= 0;
  end

  task automatic resetDut(input int ws);
    @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0; i_req = 1'b0; h_req = 1'b0;
    d_we = 1'b0; h_we = 1'b0;
    waitStates = ws;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bit got;
    @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b1; i_req = 1'b1; h_req = 1'b1;
    d_we = 1'b0; h_we = 1'b0;
    d_addr = 32'h10; i_addr = 32'h20; h_addr = 32'h30;
    d_wdata = 32'h1111_1111; h_wdata = 32'h2222_2222;
    waitStates = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({d_valid, i_valid, h_valid} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL reset_valids got=%b exp=000", {d_valid, i_valid, h_valid});
    end
    vectors++;
    if (ram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_req got=%b exp=0", ram_req); end
    vectors++;
    if (ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_we got=%b exp=0", ram_we); end
    vectors++;
    if (ram_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    vectors++;
    if (ram_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
    vectors++;
    if (starve_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_starve got=%0d exp=0", starve_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h10) begin
      miscompares++; $display("[TB] FAIL reset_first_grant got req=%b addr=%h exp req=1 addr=10", ram_req, ram_addr);
    end
    d_req = 1'b0; i_req = 1'b0; h_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (d_valid) begin got = 1'b1; break; end
    end
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_first_valid got=%b exp=1", got); end
  endtask

  task automatic test_single_read;
    int reqCyc;
    bit got;
    resetDut(2);
    reqCyc = 0; got = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_req) begin
        reqCyc++;
        if (reqCyc == 1) begin
          vectors++;
          if (ram_addr !== 32'h100 || ram_we !== 1'b0) begin
            miscompares++; $display("[TB] FAIL read_issue got addr=%h we=%b exp addr=100 we=0", ram_addr, ram_we);
          end
        end
      end
      if (d_valid) begin
        got = 1'b1;
        d_req = 1'b0;
        vectors++;
        if (rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL read_rdata got=%h exp=deadbeef", rdata); end
        break;
      end
    end
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL read_valid_timeout got=%b exp=1", got); end
    vectors++;
    if (reqCyc != 3) begin miscompares++; $display("[TB] FAIL read_req_cycles got=%0d exp=3", reqCyc); end
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_valid_width got=%b exp=0", d_valid); end
  endtask

  task automatic test_priority;
    int dCyc, iCyc, hCyc, hExp;
`ifdef MEM_ARB_HOST_PORT_EN
    hExp = 6;
`else
    hExp = -1;
`endif
    resetDut(0);
    dCyc = -1; iCyc = -1; hCyc = -1;
    d_addr = 32'h200; i_addr = 32'h300; h_addr = 32'h3F0;
    d_we = 1'b0; h_we = 1'b0;
    d_req = 1'b1; i_req = 1'b1; h_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if (starve_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL prio_starve_after_d got=%0d exp=1", starve_cnt); end
      end
      if (k == 3) begin
        vectors++;
        if (starve_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL prio_starve_after_i got=%0d exp=0", starve_cnt); end
      end
      if (d_valid && dCyc < 0) begin dCyc = k; d_req = 1'b0; end
      if (i_valid && iCyc < 0) begin iCyc = k; i_req = 1'b0; end
      if (h_valid && hCyc < 0) begin hCyc = k; h_req = 1'b0; end
    end
    h_req = 1'b0;
    vectors++;
    if (dCyc != 2) begin miscompares++; $display("[TB] FAIL prio_d_cycle got=%0d exp=2", dCyc); end
    vectors++;
    if (iCyc != 4) begin miscompares++; $display("[TB] FAIL prio_i_cycle got=%0d exp=4", iCyc); end
    vectors++;
    if (hCyc != hExp) begin miscompares++; $display("[TB] FAIL prio_h_cycle got=%0d exp=%0d", hCyc, hExp); end
  endtask

  task automatic test_starvation;
    resetDut(0);
    d_addr = 32'h200; i_addr = 32'h300; d_we = 1'b0;
    for (int g = 1; g <= 4; g++) begin
      d_req = 1'b1; i_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (ram_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL starve_grant_d%0d got addr=%h exp=200", g, ram_addr); end
      vectors++;
      if (starve_cnt !== 4'(g)) begin miscompares++; $display("[TB] FAIL starve_cnt%0d got=%0d exp=%0d", g, starve_cnt, g); end
      i_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (d_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_d_valid%0d got=%b exp=1", g, d_valid); end
      d_req = 1'b0;
      @(negedge clk);
    end
    d_req = 1'b1; i_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (ram_addr !== 32'h300) begin miscompares++; $display("[TB] FAIL starve_override got addr=%h exp=300", ram_addr); end
    vectors++;
    if (starve_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL starve_clear got=%0d exp=0", starve_cnt); end
    i_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (i_valid !== 1'b1 || rdata !== 32'h1000_00C0) begin
      miscompares++; $display("[TB] FAIL starve_i_done got valid=%b rdata=%h exp valid=1 rdata=100000c0", i_valid, rdata);
    end
    @(negedge clk);
    vectors++;
    if (ram_addr !== 32'h200 || ram_req !== 1'b1 || starve_cnt !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL starve_back_to_back got addr=%h req=%b cnt=%0d exp addr=200 req=1 cnt=0", ram_addr, ram_req, starve_cnt);
    end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read;
    resetDut(0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== 32'h40 || ram_wdata !== 32'h5A5A_5A5A) begin
      miscompares++;
      $display("[TB] FAIL wr_issue got we=%b addr=%h wdata=%h exp we=1 addr=40 wdata=5a5a5a5a", ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b1 || rdata !== 32'h0) begin
      miscompares++; $display("[TB] FAIL wr_done got valid=%b rdata=%h exp valid=1 rdata=0", d_valid, rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b0 || ram_addr !== 32'h40) begin
      miscompares++; $display("[TB] FAIL rd_issue got we=%b addr=%h exp we=0 addr=40", ram_we, ram_addr);
    end
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b1 || rdata !== 32'h5A5A_5A5A) begin
      miscompares++; $display("[TB] FAIL rd_done got valid=%b rdata=%h exp valid=1 rdata=5a5a5a5a", d_valid, rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    bit sawValid;
    bit got;
    int reqCyc;
    resetDut(5);
    i_addr = 32'h300; i_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h300) begin
      miscompares++; $display("[TB] FAIL midrst_issue got req=%b addr=%h exp req=1 addr=300", ram_req, ram_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_req_drop got=%b exp=0", ram_req); end
    sawValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_valid || i_valid || h_valid) sawValid = 1'b1;
    end
    vectors++;
    if (sawValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_no_valid got=%b exp=0", sawValid); end
    rst_n = 1'b1;
    got = 1'b0; reqCyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_req) reqCyc++;
      if (i_valid) begin got = 1'b1; break; end
    end
    i_req = 1'b0;
    vectors++;
    if (got !== 1'b1 || reqCyc != 6) begin
      miscompares++; $display("[TB] FAIL midrst_resume got valid=%b reqcyc=%0d exp valid=1 reqcyc=6", got, reqCyc);
    end
    vectors++;
    if (rdata !== 32'h1000_00C0) begin miscompares++; $display("[TB] FAIL midrst_rdata got=%h exp=100000c0", rdata); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_addr = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    waitStates = 0;
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_write_read();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
